// File: rtl/fetch_pc.sv
// Program counter and next-address selection for the single-cycle CPU.
// Handles increment, jump, call/ret via a return stack and one-level irq.
module fetch_pc #(
    parameter int         DEPTH      = 4,
    parameter logic [9:0] RESET_ADDR = 10'd0,
    parameter logic [9:0] VECTOR     = 10'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       jump,
    input  logic       call,
    input  logic       ret,
    input  logic       reti,
    input  logic       irq,
    input  logic [9:0] target,
    output logic [9:0] a,
    output logic       in_isr,
    output logic       stk_ovf,
    output logic       stk_unf
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int SLOTS = 1 << SPW;
    localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

    logic [9:0]     pc;
    logic [9:0]     epc;
    logic [9:0]     pc_inc;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_dec;
    logic [9:0]     stack [SLOTS];

    logic sel_irq;
    logic sel_reti;
    logic sel_ret;
    logic sel_call;
    logic sel_jump;

    assign a      = pc;
    assign pc_inc = pc + 10'd1;
    assign sp_dec = sp - SPW'(1);

    // One-hot select so the priority chain is explicit.
    always_comb begin
        sel_irq  = irq & ~in_isr & ~call & ~ret & ~reti;
        sel_reti = reti;
        sel_ret  = ret & ~reti;
        sel_call = call & ~ret & ~reti;
        sel_jump = jump & ~call & ~ret & ~reti & ~sel_irq;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_ADDR;
            epc     <= '0;
            sp      <= '0;
            in_isr  <= 1'b0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                stack[i] <= '0;
            end
        end else if (!stall) begin
            unique case (1'b1)
                sel_irq: begin
                    epc    <= jump ? target : pc_inc;
                    pc     <= VECTOR;
                    in_isr <= 1'b1;
                end
                sel_reti: begin
                    if (in_isr) begin
                        pc     <= epc;
                        in_isr <= 1'b0;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                sel_ret: begin
                    if (sp != '0) begin
                        pc <= stack[sp_dec];
                        sp <= sp_dec;
                    end else begin
                        pc      <= pc_inc;
                        stk_unf <= 1'b1;
                    end
                end
                sel_call: begin
                    if (sp != FULL) begin
                        stack[sp] <= pc_inc;
                        sp        <= sp + SPW'(1);
                    end else begin
                        stk_ovf <= 1'b1;
                    end
                    pc <= target;
                end
                sel_jump: pc <= target;
                default:  pc <= pc_inc;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: directed sequences then random strobes,
// checked against a queue-based reference model of the next-PC rules.
module tb_fetch_pc;
    localparam int DEPTH = 4;
    localparam int RST_A = 0;
    localparam int VEC   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0;
    logic       jump = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       reti = 1'b0;
    logic       irq = 1'b0;
    logic [9:0] target = '0;
    logic [9:0] a;
    logic       in_isr;
    logic       stk_ovf;
    logic       stk_unf;

    fetch_pc #(
        .DEPTH(DEPTH),
        .RESET_ADDR(10'd0),
        .VECTOR(10'd1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .jump(jump),
        .call(call),
        .ret(ret),
        .reti(reti),
        .irq(irq),
        .target(target),
        .a(a),
        .in_isr(in_isr),
        .stk_ovf(stk_ovf),
        .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int isr;
        int ovf;
        int unf;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    int m_pc, m_epc, m_isr, m_ovf, m_unf;
    int m_stk[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input exp_t e);
        chk({nm, ".a"}, int'(a), e.a);
        chk({nm, ".in_isr"}, int'(in_isr), e.isr);
        chk({nm, ".stk_ovf"}, int'(stk_ovf), e.ovf);
        chk({nm, ".stk_unf"}, int'(stk_unf), e.unf);
    endtask

    function automatic void m_reset();
        m_pc = RST_A;
        m_epc = 0;
        m_isr = 0;
        m_ovf = 0;
        m_unf = 0;
        m_stk.delete();
    endfunction

    function automatic exp_t m_now();
        exp_t e;
        e.a = m_pc;
        e.isr = m_isr;
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    function automatic void m_step(input int st, input int j,
                                   input int c, input int r,
                                   input int ri, input int iq,
                                   input int tg);
        int nxt;
        nxt = (m_pc + 1) % 1024;
        if (st != 0) return;
        if (iq != 0 && m_isr == 0 && c == 0 && r == 0 && ri == 0) begin
            m_epc = (j != 0) ? tg : nxt;
            m_pc = VEC;
            m_isr = 1;
        end else if (ri != 0) begin
            if (m_isr != 0) begin
                m_pc = m_epc;
                m_isr = 0;
            end else begin
                m_pc = nxt;
            end
        end else if (r != 0) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc = nxt;
                m_unf = 1;
            end
        end else if (c != 0) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
            else m_ovf = 1;
            m_pc = tg;
        end else if (j != 0) begin
            m_pc = tg;
        end else begin
            m_pc = nxt;
        end
    endfunction

    // Drive one cycle of strobes at the falling edge, model it, queue result.
    task automatic cyc(input int st, input int j, input int c,
                       input int r, input int ri, input int iq,
                       input int tg);
        @(negedge clk);
        reset = 1'b1;
        stall = st[0];
        jump = j[0];
        call = c[0];
        ret = r[0];
        reti = ri[0];
        irq = iq[0];
        target = 10'(tg);
        m_step(st, j, c, r, ri, iq, tg);
        q.push_back(m_now());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b0;
        stall = 1'b0;
        jump = 1'b0;
        call = 1'b0;
        ret = 1'b0;
        reti = 1'b0;
        irq = 1'b0;
        m_reset();
        #1;
        chk_all(nm, m_now());
        @(posedge clk);
        #1;
        chk_all({nm, "_hold"}, m_now());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all("cycle", e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int st, j, c, r, ri, iq, tg;
        m_reset();
        @(negedge clk);
        do_reset("reset");

        idle(5);
        cyc(0, 1, 0, 0, 0, 0, 1022);
        idle(2);

        cyc(0, 1, 0, 0, 0, 0, 7);
        cyc(0, 1, 0, 0, 0, 0, 100);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 500);
        cyc(1, 0, 0, 1, 0, 0, 0);
        idle(1);

        cyc(0, 1, 0, 0, 0, 0, 10);
        cyc(0, 0, 1, 0, 0, 0, 200);
        cyc(0, 0, 1, 0, 0, 0, 300);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 400 + i);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 50);
        cyc(0, 0, 0, 1, 0, 0, 0);
        idle(3);

        @(negedge clk);
        do_reset("reset2");
        cyc(0, 1, 0, 0, 0, 0, 20);
        cyc(0, 1, 0, 0, 0, 1, 40);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 30);
        cyc(0, 0, 1, 0, 0, 1, 80);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 90);
        cyc(0, 0, 0, 0, 0, 1, 0);

        @(posedge clk);
        #3;
        do_reset("reset_isr");

        for (int k = 0; k < 600; k++) begin
            st = ($urandom_range(0, 9) == 0) ? 1 : 0;
            j = ($urandom_range(0, 5) == 0) ? 1 : 0;
            c = ($urandom_range(0, 5) == 0) ? 1 : 0;
            r = ($urandom_range(0, 5) == 0) ? 1 : 0;
            ri = ($urandom_range(0, 7) == 0) ? 1 : 0;
            iq = ($urandom_range(0, 6) == 0) ? 1 : 0;
            tg = int'($urandom_range(0, 1023));
            cyc(st, j, c, r, ri, iq, tg);
            if (k == 300) begin
                @(posedge clk);
                #2;
                do_reset("reset_rand");
            end
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
